// File: rtl/wbcrouter_reg.sv
// -----------------------------------------------------------------------------
// wbcrouter_reg
//
// Registered Wishbone classic router: one master, NS slaves, one outstanding
// transaction at a time. Slaves are selected by base/mask decode. If several
// slaves match, the lowest index wins. The request and response paths are
// both registered, so there is no combinational path from master to slave.
//
// Error and abort behaviour:
//   - Decode misses end with a bus error.
//   - With WBCROUTER_TIMEOUT_EN defined, a selected slave that gives no
//     ack/err within TIMEOUT wait cycles also ends with a bus error.
//   - If the master drops i_mcyc mid-transaction, the transaction is
//     abandoned silently.
//
// Build option:
//   WBCROUTER_TIMEOUT_EN
//     Defined:   the wait-cycle counter and the timeout error path are built.
//     Undefined: the counter is not built and TIMEOUT is ignored.
//
// Parameters:
//   NS                       number of slaves
//   AW / DW / SW             address, data and byte-select widths
//   SLAVE_BASE / SLAVE_MASK  per-slave base and mask, slave g in [g*AW +: AW]
//   TIMEOUT                  wait cycles before a hung slave is errored (>= 1)
//
// Ports:
//   i_clk, i_reset                clock; asynchronous active-high reset
//   i_mcyc, i_mstb, i_mwe         master cycle, strobe and write enable
//   i_maddr, i_mdata, i_msel      master address, write data, byte selects
//   o_mack, o_merr, o_mdata       registered master response
//   o_scyc, o_sstb, o_swe         per-slave cycle, strobe and write enable
//                                 (one-hot, registered)
//   o_saddr                       per-slave offset address (addr & ~MASK_g)
//   o_sdata, o_ssel               write data and byte selects, same on all lanes
//   i_sack, i_serr, i_sdata       per-slave ack, error and read data
// -----------------------------------------------------------------------------
module wbcrouter_reg #(
    parameter int                NS         = 8,
    parameter int                AW         = 32,
    parameter int                DW         = 32,
    parameter int                SW         = DW / 8,
    parameter logic [NS*AW-1:0]  SLAVE_BASE = '0,
    parameter logic [NS*AW-1:0]  SLAVE_MASK = '0,
    parameter int                TIMEOUT    = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_mcyc,
    input  logic                 i_mstb,
    input  logic                 i_mwe,
    input  logic [AW-1:0]        i_maddr,
    input  logic [DW-1:0]        i_mdata,
    input  logic [SW-1:0]        i_msel,
    output logic                 o_mack,
    output logic                 o_merr,
    output logic [DW-1:0]        o_mdata,
    output logic [NS-1:0]        o_scyc,
    output logic [NS-1:0]        o_sstb,
    output logic [NS-1:0]        o_swe,
    output logic [NS*AW-1:0]     o_saddr,
    output logic [NS*DW-1:0]     o_sdata,
    output logic [NS*SW-1:0]     o_ssel,
    input  logic [NS-1:0]        i_sack,
    input  logic [NS-1:0]        i_serr,
    input  logic [NS*DW-1:0]     i_sdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [NS-1:0]    stb_reg,   stb_next;    // one-hot slave select, live only in WAIT
    logic [NS-1:0]    swe_reg,   swe_next;
    logic [AW-1:0]    addr_reg,  addr_next;
    logic [DW-1:0]    wdata_reg, wdata_next;
    logic [SW-1:0]    msel_reg,  msel_next;
    logic             mack_reg,  mack_next;
    logic             merr_reg,  merr_next;
    logic [DW-1:0]    mdata_reg, mdata_next;

`ifdef WBCROUTER_TIMEOUT_EN
    localparam int            CW          = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    logic [CW-1:0]    count_reg, count_next;
`endif

    // ------------------------------------------------------------------
    // Address decode and the per-lane slave-side views.
    // ------------------------------------------------------------------
    logic [NS-1:0]    dec_hit;
    logic [NS-1:0]    dec_onehot;
    logic [DW-1:0]    rdata_lane [NS];
    logic [DW-1:0]    sel_rdata;
    logic             sel_ack;
    logic             sel_err;

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_lane
            assign dec_hit[gi] = ((i_maddr & SLAVE_MASK[gi*AW +: AW]) ==
                                  (SLAVE_BASE[gi*AW +: AW] & SLAVE_MASK[gi*AW +: AW]));
            assign rdata_lane[gi]          = stb_reg[gi] ? i_sdata[gi*DW +: DW] : '0;
            assign o_saddr[gi*AW +: AW]    = addr_reg & ~SLAVE_MASK[gi*AW +: AW];
            assign o_sdata[gi*DW +: DW]    = wdata_reg;
            assign o_ssel[gi*SW +: SW]     = msel_reg;
        end
    endgenerate

    // Keep only the lowest set bit, so the lowest-indexed hit wins.
    assign dec_onehot = dec_hit & (~dec_hit + NS'(1));

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            sel_rdata = sel_rdata | rdata_lane[i];
        end
    end

    // Ack and error from slaves that are not selected are masked off here.
    assign sel_ack = |(i_sack & stb_reg);
    assign sel_err = |(i_serr & stb_reg);

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        stb_next   = stb_reg;
        swe_next   = swe_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        msel_next  = msel_reg;
        mack_next  = 1'b0;
        merr_next  = 1'b0;
        mdata_next = mdata_reg;
`ifdef WBCROUTER_TIMEOUT_EN
        count_next = count_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (i_mcyc && i_mstb) begin
                    addr_next  = i_maddr;
                    wdata_next = i_mdata;
                    msel_next  = i_msel;
                    stb_next   = dec_onehot;
                    swe_next   = dec_onehot & {NS{i_mwe}};
`ifdef WBCROUTER_TIMEOUT_EN
                    count_next = '0;
`endif
                    // A decode miss also passes through WAIT, with no slave
                    // selected. Its error then appears on the same cycle as
                    // a zero-wait slave's ack would.
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!i_mcyc) begin
                    // Master abort has priority over any same-cycle response.
                    stb_next   = '0;
                    swe_next   = '0;
                    state_next = ST_IDLE;
                end else if (~|stb_reg || sel_err) begin
                    // Decode miss, or slave error (error beats a same-cycle ack).
                    merr_next  = 1'b1;
                    mdata_next = '0;
                    stb_next   = '0;
                    swe_next   = '0;
                    state_next = ST_RESP;
                end else if (sel_ack) begin
                    mack_next  = 1'b1;
                    mdata_next = sel_rdata;
                    stb_next   = '0;
                    swe_next   = '0;
                    state_next = ST_RESP;
                end
`ifdef WBCROUTER_TIMEOUT_EN
                else if (count_reg == TIMEOUT_CNT) begin
                    merr_next  = 1'b1;
                    mdata_next = '0;
                    stb_next   = '0;
                    swe_next   = '0;
                    state_next = ST_RESP;
                end else begin
                    count_next = count_reg + CW'(1);
                end
`endif
            end

            ST_RESP: begin
                // The master bus is deliberately not sampled here. A strobe
                // still held from the last request must not be issued twice.
                state_next = ST_IDLE;
            end

            default: begin
                stb_next   = '0;
                swe_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            stb_reg   <= '0;
            swe_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            msel_reg  <= '0;
            mack_reg  <= 1'b0;
            merr_reg  <= 1'b0;
            mdata_reg <= '0;
`ifdef WBCROUTER_TIMEOUT_EN
            count_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            stb_reg   <= stb_next;
            swe_reg   <= swe_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            msel_reg  <= msel_next;
            mack_reg  <= mack_next;
            merr_reg  <= merr_next;
            mdata_reg <= mdata_next;
`ifdef WBCROUTER_TIMEOUT_EN
            count_reg <= count_next;
`endif
        end
    end

    assign o_scyc  = stb_reg;
    assign o_sstb  = stb_reg;
    assign o_swe   = swe_reg;
    assign o_mack  = mack_reg;
    assign o_merr  = merr_reg;
    assign o_mdata = mdata_reg;

endmodule
